// File: rtl/dcache_setassoc_if.sv
// dcache_setassoc_if: bundles the datapath-side request port and the
// memory-side data channel of the set-associative data cache.
// Ports: slave = cache view (requests/dwait/dload in, dhit/bus requests out);
//        master = environment view (datapath + memory controller).
interface dcache_setassoc_if;
  // datapath side
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  // memory side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_setassoc.sv
// dcache_setassoc: write-back, write-allocate, NWAYS-way set-associative data
// cache with true-LRU replacement and a halt-time flush of all dirty lines.
// Ports: CLK, n_rst (async active-low), bus (dcache_setassoc_if.slave).
// Optional: define DCACHE_HITCOUNT_EN to keep a hit counter that is written
// to HITADDR after the flush; without it the flush ends directly in HALTED.
module dcache_setassoc #(
  parameter int          NSETS    = 8,
  parameter int          NWAYS    = 2,
  parameter int          BLKWORDS = 2,
  parameter logic [31:0] HITADDR  = 32'h3100
) (
  input logic              CLK,
  input logic              n_rst,
  dcache_setassoc_if.slave bus
);
  localparam int OW = $clog2(BLKWORDS);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 32 - 2 - OW - IW;
  localparam int WW = (NWAYS > 1) ? $clog2(NWAYS) : 1;

  localparam logic [OW-1:0] LAST_BEAT = OW'(BLKWORDS - 1);
  localparam logic [IW-1:0] LAST_SET  = IW'(NSETS - 1);
  localparam logic [WW-1:0] LAST_WAY  = WW'(NWAYS - 1);
  localparam logic [WW-1:0] OLDEST    = WW'(NWAYS - 1);

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT, HALTED} state_t;
  state_t state;

  // line storage
  logic [NWAYS-1:0] valid [NSETS];
  logic [NWAYS-1:0] dirty [NSETS];
  logic [TW-1:0]    tags  [NSETS][NWAYS];
  logic [WW-1:0]    age   [NSETS][NWAYS];
  logic [31:0]      data  [NSETS][NWAYS][BLKWORDS];
  logic [31:0]      fill_buf [BLKWORDS];

  // miss / flush bookkeeping
  logic [TW-1:0] m_tag;
  logic [IW-1:0] m_idx;
  logic [WW-1:0] m_way;
  logic [OW-1:0] beat;
  logic [IW-1:0] f_set;
  logic [WW-1:0] f_way;

  // registered bus outputs
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdat;
  logic        flush_done;

  // request decode
  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [OW-1:0] req_off;
  logic          req;
  logic          unused_bits;

  assign req_tag     = bus.dmemaddr[31 -: TW];
  assign req_idx     = bus.dmemaddr[2+OW +: IW];
  assign req_off     = bus.dmemaddr[2 +: OW];
  assign req         = bus.dmemREN | bus.dmemWEN;
  assign unused_bits = ^bus.dmemaddr[1:0];

  // lookup and victim choice
  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] old_way;
  logic          found_inv;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_way   = '0;
    old_way   = '0;
    found_inv = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (age[req_idx][w] == OLDEST)
        old_way = WW'(w);
    end
    // descending scan so the lowest-index invalid way wins
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) begin
        found_inv = 1'b1;
        inv_way   = WW'(w);
      end
    end
    victim = found_inv ? inv_way : old_way;
  end

  logic dhit;
  logic done;
  logic fill_beat;
  logic flush_adv;

  assign dhit      = (state == IDLE) && !bus.halt && req && hit;
  assign done      = (mem_ren | mem_wen) & ~bus.dwait;
  assign fill_beat = (state == FILL) && done;
  // a flush line is finished when its last write beat lands, or at once if
  // there is nothing to write back
  assign flush_adv = (state == FLUSH) &&
                     (mem_wen ? (done && beat == LAST_BEAT)
                              : !(valid[f_set][f_way] && dirty[f_set][f_way]));

  assign bus.dhit     = dhit;
  assign bus.dmemload = (dhit && bus.dmemREN) ? data[req_idx][hit_way][req_off] : '0;
  assign bus.flushed  = flush_done;
  assign bus.dREN     = mem_ren;
  assign bus.dWEN     = mem_wen;
  assign bus.daddr    = mem_addr;
  assign bus.dstore   = mem_wdat;

`ifdef DCACHE_HITCOUNT_EN
  logic [31:0] hit_cnt;
  logic        after_fill;

  // the re-lookup hit that completes a miss is not a real hit
  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      hit_cnt    <= '0;
      after_fill <= 1'b0;
    end else begin
      if (fill_beat && beat == LAST_BEAT)
        after_fill <= 1'b1;
      else if (state == IDLE)
        after_fill <= 1'b0;
      if (dhit && !after_fill)
        hit_cnt <= hit_cnt + 32'd1;
    end
  end
`endif

  // data array: store hits and whole-line install at the end of a fill
  always_ff @(posedge CLK) begin
    if (dhit && bus.dmemWEN)
      data[req_idx][hit_way][req_off] <= bus.dmemstore;
    if (fill_beat) begin
      fill_buf[beat] <= bus.dload;
      if (beat == LAST_BEAT)
        for (int b = 0; b < BLKWORDS; b++)
          data[m_idx][m_way][b] <= (OW'(b) == beat) ? bus.dload : fill_buf[b];
    end
  end

  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdat   <= '0;
      flush_done <= 1'b0;
      m_tag      <= '0;
      m_idx      <= '0;
      m_way      <= '0;
      beat       <= '0;
      f_set      <= '0;
      f_way      <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < NWAYS; w++) begin
          tags[s][w] <= '0;
          age[s][w]  <= WW'(w);
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.halt) begin
            state <= FLUSH;
            f_set <= '0;
            f_way <= '0;
            beat  <= '0;
          end else if (req) begin
            if (hit) begin
              // true LRU: accessed way becomes youngest, younger ones age
              for (int w = 0; w < NWAYS; w++) begin
                if (WW'(w) == hit_way)
                  age[req_idx][w] <= '0;
                else if (age[req_idx][w] < age[req_idx][hit_way])
                  age[req_idx][w] <= age[req_idx][w] + 1'b1;
              end
              if (bus.dmemWEN)
                dirty[req_idx][hit_way] <= 1'b1;
            end else begin
              m_tag <= req_tag;
              m_idx <= req_idx;
              m_way <= victim;
              beat  <= '0;
              if (valid[req_idx][victim] && dirty[req_idx][victim]) begin
                state    <= WB;
                mem_wen  <= 1'b1;
                mem_addr <= {tags[req_idx][victim], req_idx, OW'(0), 2'b00};
                mem_wdat <= data[req_idx][victim][0];
              end else begin
                state    <= FILL;
                mem_ren  <= 1'b1;
                mem_addr <= {req_tag, req_idx, OW'(0), 2'b00};
              end
            end
          end
        end

        WB: begin
          if (done) begin
            if (beat == LAST_BEAT) begin
              state    <= FILL;
              beat     <= '0;
              mem_wen  <= 1'b0;
              mem_ren  <= 1'b1;
              mem_addr <= {m_tag, m_idx, OW'(0), 2'b00};
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= {tags[m_idx][m_way], m_idx, beat + 1'b1, 2'b00};
              mem_wdat <= data[m_idx][m_way][beat + 1'b1];
            end
          end
        end

        FILL: begin
          if (done) begin
            if (beat == LAST_BEAT) begin
              state               <= IDLE;
              beat                <= '0;
              mem_ren             <= 1'b0;
              valid[m_idx][m_way] <= 1'b1;
              dirty[m_idx][m_way] <= 1'b0;
              tags[m_idx][m_way]  <= m_tag;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= {m_tag, m_idx, beat + 1'b1, 2'b00};
            end
          end
        end

        FLUSH: begin
          if (mem_wen) begin
            if (done && beat != LAST_BEAT) begin
              beat     <= beat + 1'b1;
              mem_addr <= {tags[f_set][f_way], f_set, beat + 1'b1, 2'b00};
              mem_wdat <= data[f_set][f_way][beat + 1'b1];
            end
          end else if (valid[f_set][f_way] && dirty[f_set][f_way]) begin
            mem_wen  <= 1'b1;
            beat     <= '0;
            mem_addr <= {tags[f_set][f_way], f_set, OW'(0), 2'b00};
            mem_wdat <= data[f_set][f_way][0];
          end
          if (flush_adv) begin
            valid[f_set][f_way] <= 1'b0;
            dirty[f_set][f_way] <= 1'b0;
            mem_wen             <= 1'b0;
            beat                <= '0;
            if (f_way == LAST_WAY) begin
              f_way <= '0;
              if (f_set == LAST_SET) begin
`ifdef DCACHE_HITCOUNT_EN
                state    <= CNT;
                mem_wen  <= 1'b1;
                mem_addr <= HITADDR;
                mem_wdat <= hit_cnt;
`else
                state      <= HALTED;
                flush_done <= 1'b1;
`endif
              end else begin
                f_set <= f_set + 1'b1;
              end
            end else begin
              f_way <= f_way + 1'b1;
            end
          end
        end

        CNT: begin
          if (done) begin
            state      <= HALTED;
            mem_wen    <= 1'b0;
            flush_done <= 1'b1;
          end
        end

        HALTED: begin
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_setassoc.sv
module tb_dcache_setassoc;
  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  dcache_setassoc_if bus ();

  dcache_setassoc dut (
    .CLK   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // ---------------- memory model ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } beat_t;

  logic [31:0] mem [4096];
  beat_t       log_q [$];
  int          stall_n = 0;
  int          wcnt    = 0;

  assign bus.dwait = (bus.dREN | bus.dWEN) && (wcnt < stall_n);
  assign bus.dload = mem[bus.daddr[13:2]];

  always @(posedge clk) begin
    if (bus.dREN | bus.dWEN) begin
      if (wcnt < stall_n) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (bus.dWEN) mem[bus.daddr[13:2]] <= bus.dstore;
        log_q.push_back('{bus.dWEN, bus.daddr, bus.dWEN ? bus.dstore : bus.dload});
      end
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request and holds it until dhit; returns load data and
  // the number of cycles from request to dhit (1 = hit).
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    @(negedge clk);
    bus.dmemREN   = !we;
    bus.dmemWEN   = we;
    bus.dmemaddr  = a;
    bus.dmemstore = wd;
    cyc = 0;
    rd  = '0;
    for (int i = 0; i < 100; i++) begin
      #1;
      cyc++;
      if (bus.dhit) begin
        rd = bus.dmemload;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    int          cyc;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          found;
    int          unstable;
    int          stalls;
    int          nhits;
    int          sz;
    int          n_fl;
    logic        prev_wait;
    logic        prev_ren;
    logic [31:0] prev_addr;
    logic [31:0] fl_addr [7];
    logic [31:0] fl_dat  [7];

    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 4);
    mem[64] = 32'hDEADBEEF;  // word at 0x100

    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dmemaddr = '0;
    bus.dmemstore = '0; bus.halt = 1'b0;

    // ---- reset values ----
    #2 n_rst = 1'b0;
    #1;
    check("reset_ctl", 32'({bus.dREN, bus.dWEN, bus.dhit, bus.flushed}), 32'h0);
    check("reset_daddr", bus.daddr, 32'h0);
    check("reset_dstore", bus.dstore, 32'h0);
    check("reset_dmemload", bus.dmemload, 32'h0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk); #1;
    check("idle_ctl", 32'({bus.dREN, bus.dWEN, bus.dhit, bus.flushed}), 32'h0);

    // ---- dwait held 5 cycles per beat ----
    stall_n = 5;
    @(negedge clk);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h400;
    cyc = 0; unstable = 0; stalls = 0; rd = '0;
    prev_wait = 1'b0; prev_ren = 1'b0; prev_addr = '0;
    for (int i = 0; i < 100; i++) begin
      #1;
      cyc++;
      if (bus.dhit) begin
        rd = bus.dmemload;
        break;
      end
      if (prev_wait && (bus.daddr != prev_addr || bus.dREN != prev_ren)) unstable++;
      prev_wait = bus.dwait; prev_addr = bus.daddr; prev_ren = bus.dREN;
      if (bus.dwait) stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    bus.dmemREN = 1'b0;
    check("stall_cycles", 32'(cyc), 32'd14);
    check("stall_data", rd, 32'hC0DE0400);
    check("stall_unstable", 32'(unstable), 32'd0);
    check("stall_count", 32'(stalls), 32'd10);
    stall_n = 0;

    // ---- reset during fill beat 1 ----
    stall_n = 3;
    @(negedge clk);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h500;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.dREN && bus.daddr == 32'h504) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reach_beat1", 32'(found), 32'd1);
    n_rst = 1'b0;
    #1;
    check("rst_mid_ctl", 32'({bus.dREN, bus.dWEN, bus.dhit, bus.flushed}), 32'h0);
    check("rst_mid_daddr", bus.daddr, 32'h0);
    check("rst_mid_dmemload", bus.dmemload, 32'h0);
    bus.dmemREN = 1'b0;
    stall_n = 0;
    @(negedge clk);
    n_rst = 1'b1;
    access(1'b0, 32'h500, 32'h0, rd, cyc);
    check("rst_remiss_cycles", 32'(cyc), 32'd4);
    check("rst_remiss_data", rd, 32'hC0DE0500);

    // ---- request dropped mid-miss ----
    @(negedge clk);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h700;
    @(negedge clk);
    bus.dmemREN = 1'b0;
    nhits = 0; found = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.dhit) nhits++;
      if (!bus.dREN && !bus.dWEN) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("drop_fill_ends", 32'(found), 32'd1);
    check("drop_no_dhit", 32'(nhits), 32'd0);
    access(1'b0, 32'h700, 32'h0, rd, cyc);
    check("drop_installed_cycles", 32'(cyc), 32'd1);
    check("drop_installed_data", rd, 32'hC0DE0700);

    // clean start for the table and the hit count
    @(negedge clk); n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1;

    // ---- vector table (default geometry: index = addr[5:3]) ----
    vecs[0]  = '{1'b0, 32'h100, 32'hDEADBEEF, 4};  // cold miss
    vecs[1]  = '{1'b0, 32'h104, 32'hC0DE0104, 1};
    vecs[2]  = '{1'b1, 32'h100, 32'h00000011, 1};  // store hit -> dirty
    vecs[3]  = '{1'b0, 32'h100, 32'h00000011, 1};
    vecs[4]  = '{1'b0, 32'h200, 32'hC0DE0200, 4};  // set 0 way 1
    vecs[5]  = '{1'b0, 32'h300, 32'hC0DE0300, 6};  // evicts dirty 0x100
    vecs[6]  = '{1'b0, 32'h100, 32'h00000011, 4};  // written-back data
    vecs[7]  = '{1'b0, 32'h008, 32'hC0DE0008, 4};  // A
    vecs[8]  = '{1'b0, 32'h048, 32'hC0DE0048, 4};  // B
    vecs[9]  = '{1'b0, 32'h008, 32'hC0DE0008, 1};  // A
    vecs[10] = '{1'b0, 32'h088, 32'hC0DE0088, 4};  // C replaces B
    vecs[11] = '{1'b0, 32'h008, 32'hC0DE0008, 1};  // A still hits
    vecs[12] = '{1'b0, 32'h048, 32'hC0DE0048, 4};  // B gone
    vecs[13] = '{1'b1, 32'h010, 32'h00000055, 4};  // store miss allocates
    vecs[14] = '{1'b0, 32'h010, 32'h00000055, 1};
    vecs[15] = '{1'b0, 32'h014, 32'hC0DE0014, 1};
    vecs[16] = '{1'b1, 32'h300, 32'h00000066, 1};
    vecs[17] = '{1'b1, 32'h00C, 32'h00000077, 1};
    vecs[18] = '{1'b0, 32'h300, 32'h00000066, 1};

    for (int i = 0; i < 19; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].dat, rd, cyc);
      if (!vecs[i].we) check($sformatf("vec%0d_data", i), rd, vecs[i].dat);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
    end
    check("wb_mem_100", mem[64], 32'h00000011);
    check("wb_mem_104", mem[65], 32'hC0DE0104);

    // ---- halt and flush ----
    fl_addr[0] = 32'h300;  fl_dat[0] = 32'h00000066;
    fl_addr[1] = 32'h304;  fl_dat[1] = 32'hC0DE0304;
    fl_addr[2] = 32'h008;  fl_dat[2] = 32'hC0DE0008;
    fl_addr[3] = 32'h00C;  fl_dat[3] = 32'h00000077;
    fl_addr[4] = 32'h010;  fl_dat[4] = 32'h00000055;
    fl_addr[5] = 32'h014;  fl_dat[5] = 32'hC0DE0014;
    fl_addr[6] = 32'h3100; fl_dat[6] = 32'd10;
`ifdef DCACHE_HITCOUNT_EN
    n_fl = 7;
`else
    n_fl = 6;
`endif
    @(negedge clk);
    log_q.delete();
    bus.halt = 1'b1;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (bus.flushed) begin
        found = 1;
        break;
      end
    end
    check("flush_done", 32'(found), 32'd1);
    sz = log_q.size();
    check("flush_beats", 32'(sz), 32'(n_fl));
    for (int i = 0; i < n_fl && i < sz; i++) begin
      check($sformatf("flush%0d_we", i), 32'(log_q[i].we), 32'd1);
      check($sformatf("flush%0d_addr", i), log_q[i].addr, fl_addr[i]);
      check($sformatf("flush%0d_dat", i), log_q[i].dat, fl_dat[i]);
    end

    // halted: sticky flushed, no hits, no bus traffic
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h300;
    nhits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.dhit) nhits++;
    end
    check("halted_dhit", 32'(nhits), 32'd0);
    check("halted_quiet", 32'(log_q.size()), 32'(sz));
    check("halted_ctl", 32'({bus.dREN, bus.dWEN, bus.flushed}), 32'b001);
    bus.dmemREN = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dcache_setassoc.md
# dcache_setassoc

Parametrised write-back, write-allocate, N-way set-associative data cache: the successor to the fixed 8-set, 2-way, 2-word-block dcache. Sits between the datapath's data port and the memory controller's data channel. Adds configurable sets, ways and block size; true-LRU replacement; and a halt-time flush that writes back every dirty line before reporting completion.

## Interface
- NSETS, 8, number of sets; power of 2, ≥2
- NWAYS, 2, associativity; power of 2, 1..8
- BLKWORDS, 2, 32-bit words per block; power of 2, ≥2
- HITADDR, 32'h3100, address for the hit-count write at halt
- CLK  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- dmemREN, dmemWEN  in  1  datapath read/write request; never both high
- dmemaddr  in  32  word-aligned byte address
- dmemstore  in  32  store data
- halt  in  1  datapath halted; level, sticky
- dhit  out  1  request satisfied this cycle
- dmemload  out  32  load data; valid when dhit && dmemREN
- flushed  out  1  flush complete
- dREN, dWEN  out  1  memory read/write request
- daddr  out  32  memory address
- dstore  out  32  memory write data
- dwait  in  1  memory busy; a beat completes on a cycle with request high and dwait low
- dload  in  32  memory read data, valid when a read beat completes

## Operation
- Address split, LSB up: 2 byte-offset bits (ignored), log2(BLKWORDS) block offset, log2(NSETS) index, remaining tag.
- Per line: valid, dirty, tag, BLKWORDS data words. Per set: NWAYS age fields of log2(NWAYS) bits, always a permutation of 0..NWAYS-1.
- States: IDLE, WB, FILL, FLUSH, CNT, HALTED.
- IDLE:
  - halt has priority over requests -> FLUSH.
  - Lookup compares all ways. On a hit, dhit=1. A load returns the word. A store writes the word and sets dirty.
  - Every hit touches LRU: the accessed way's age becomes 0, and ways with an age below its old age increment.
  - On a miss, the victim is the lowest-index invalid way, else the way with age NWAYS-1. A valid dirty victim -> WB, else FILL.
- WB: BLKWORDS write beats to {victim tag, index, beat, 2'b00}, beats 0..BLKWORDS-1. After the last beat -> FILL.
- FILL: BLKWORDS read beats from {req tag, index, beat, 2'b00}, each word captured on completion. The line is written only after the last beat: valid=1, dirty=0, new tag. Then -> IDLE, where the request re-looks-up and hits. Fill does not touch LRU; the subsequent hit does.
- FLUSH: walk set 0..NSETS-1, way 0..NWAYS-1. Each valid dirty line takes BLKWORDS write beats; clean or invalid lines cost one cycle each. Every line is invalidated as it is visited. After the last line -> CNT.
- CNT: one write beat, daddr=HITADDR, dstore=hit count. Then -> HALTED.
- HALTED: flushed=1, dhit=0, no memory requests; held until reset.
- Hit count (32-bit, wraps): increments on dhit in IDLE, except the first hit after a FILL, which counts as a miss.

## Timing
- Reset values: every output is 0. All lines invalid/clean, ages[w]=w, hit count 0, state IDLE.
- Hit: combinational, same cycle, zero wait.
- Miss latency, zero-wait memory: clean victim 1 + BLKWORDS + 1 cycles to dhit; dirty victim adds BLKWORDS.
- dREN/dWEN/daddr/dstore stay stable while dwait is high. The beat counter advances only on completion.
- A request dropped mid-miss still completes the fill; the line is installed, with no dhit.
- Reset mid-transaction aborts immediately. Bus outputs drop asynchronously and partial fills are discarded.

## Configuration
- DCACHE_HITCOUNT_EN defined: hit counter present and the CNT state is executed.
- Not defined: no counter logic; FLUSH -> HALTED directly, with no write to HITADDR.

## Test plan
- Cold load 0x0000_0100 with memory word 0xDEADBEEF and dwait=0 -> 2 read beats (0x100, 0x104), dhit on cycle 4, dmemload=0xDEADBEEF.
- Store 0x11 to 0x100, then loads to 0x200 and 0x300 (same set, default params) -> the second miss evicts the 0x100 line: writes 0x11 to 0x100 and the old word to 0x104, then fills 0x300.
- Access A, B, A in one set, then miss C -> way holding B is replaced; A still hits.
- dwait held high 5 cycles on each beat -> daddr/dREN stable throughout; data correct.
- 3 dirty lines, 10 counted hits, then halt -> 6 writebacks, then write of 10 to 0x3100; flushed=1 afterwards, and stays 1 with no further bus activity.
- Assert n_rst during FILL beat 1 -> outputs 0 immediately; the same address then misses again.
